// File: rtl/cache_nway_pkg.sv
// rtl/cache_nway_pkg.sv - shared types and address-width helpers for cache_nway
// Contents:
//   cache_state_e - controller states CHECK / WRITEBACK / ALLOCATE
//   off_width     - byte-offset bits within a line
//   idx_width     - set-index bits
//   tag_width     - tag bits left over from a 32-bit address
package cache_nway_pkg;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_e;

    function automatic int off_width(input int line_width);
        return $clog2(line_width / 8);
    endfunction

    function automatic int idx_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_width(input int line_width, input int num_sets);
        return 32 - idx_width(num_sets) - off_width(line_width);
    endfunction

endpackage

// File: rtl/cache_nway_if.sv
// rtl/cache_nway_if.sv - CPU word bus and physical-memory line bus of cache_nway
// Signals:
//   mem_*  - CPU side: read/write request held until the one-cycle mem_resp
//   pmem_* - memory side: line fill / writeback held until the one-cycle pmem_resp
// Modports: slave = cache view, master = CPU/memory environment view.
interface cache_nway_if #(
    parameter int LINE_WIDTH = 256
);
    logic                  mem_read;
    logic                  mem_write;
    logic [3:0]            mem_byte_enable;
    logic [31:0]           mem_address;
    logic [31:0]           mem_wdata;
    logic                  mem_resp;
    logic [31:0]           mem_rdata;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [31:0]           pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic                  pmem_resp;
    logic [LINE_WIDTH-1:0] pmem_rdata;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/cache_plru.sv
// rtl/cache_plru.sv - combinational tree-PLRU update and victim selection for one set
// Ports:
//   tree_i   in  NUM_WAYS-1  current tree bits (heap order, node n at bit n-1)
//   way_i    in  log2(ways)  way being accessed
//   tree_o   out NUM_WAYS-1  tree after the access (path points away from way_i)
//   victim_o out log2(ways)  way the current tree points at
module cache_plru #(
    parameter int NUM_WAYS = 4,
    localparam int WAY_W   = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] tree_i,
    input  logic [WAY_W-1:0]    way_i,
    output logic [NUM_WAYS-2:0] tree_o,
    output logic [WAY_W-1:0]    victim_o
);
    // Bit 0 is padding so the heap node number can index the vector directly.
    logic [NUM_WAYS-1:0] t_in;
    logic [NUM_WAYS-1:0] t_out;
    logic [WAY_W-1:0]    upd_node;
    logic [WAY_W-1:0]    vic_node;
    logic                unused_pad;

    assign t_in       = {tree_i, 1'b0};
    assign tree_o     = t_out[NUM_WAYS-1:1];
    assign unused_pad = t_out[0];

    // A node bit of 0 points at its lower half, 1 at its upper half.
    always_comb begin
        t_out    = t_in;
        victim_o = '0;
        upd_node = WAY_W'(1);
        vic_node = WAY_W'(1);
        for (int l = 0; l < WAY_W; l++) begin
            t_out[upd_node]         = ~way_i[WAY_W-1-l];
            victim_o[WAY_W-1-l]     = t_in[vic_node];
            upd_node = (upd_node << 1) | WAY_W'(way_i[WAY_W-1-l]);
            vic_node = (vic_node << 1) | WAY_W'(t_in[vic_node]);
        end
    end
endmodule

// File: rtl/cache_nway.sv
// rtl/cache_nway.sv - N-way set-associative write-back write-allocate cache with tree PLRU
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       CPU word interface and physical-memory line interface
//   hit_count         saturating count of requests completed without a fill
//   miss_count        saturating count of requests that caused a fill
module cache_nway
    import cache_nway_pkg::*;
#(
    parameter int NUM_WAYS   = 4,
    parameter int NUM_SETS   = 8,
    parameter int LINE_WIDTH = 256,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_nway_if.slave          bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    localparam int OFF_W  = off_width(LINE_WIDTH);
    localparam int IDX_W  = idx_width(NUM_SETS);
    localparam int TAG_W  = tag_width(LINE_WIDTH, NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int WSEL_W = OFF_W - 2;

    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
    logic [NUM_WAYS-2:0]   plru_q  [NUM_SETS];
    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];

    cache_state_e          state_q, state_d;
    logic [WAY_W-1:0]      victim_q;
    logic                  filled_q;   // current request already went through a fill

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WSEL_W-1:0]     wsel;
    logic                  req, hit, inv_found;
    logic [WAY_W-1:0]      hit_way, inv_way, plru_victim, victim_way;
    logic [NUM_WAYS-2:0]   plru_upd;
    logic [LINE_WIDTH-1:0] hit_line, merged_line;
    logic [31:0]           hit_word, merged_word;
    logic [1:0]            unused_addr_bits;

    assign idx              = bus.mem_address[OFF_W +: IDX_W];
    assign tag              = bus.mem_address[31 -: TAG_W];
    assign wsel             = bus.mem_address[2 +: WSEL_W];
    assign unused_addr_bits = bus.mem_address[1:0];
    assign req              = bus.mem_read | bus.mem_write;

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    cache_plru #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .tree_i   (plru_q[idx]),
        .way_i    (hit_way),
        .tree_o   (plru_upd),
        .victim_o (plru_victim)
    );

    assign victim_way = inv_found ? inv_way : plru_victim;

    always_comb begin
        hit_line = data_q[idx][hit_way];
        hit_word = hit_line[{wsel, 5'b0} +: 32];
        for (int b = 0; b < 4; b++) begin
            merged_word[8*b +: 8] = bus.mem_byte_enable[b] ? bus.mem_wdata[8*b +: 8]
                                                           : hit_word[8*b +: 8];
        end
        merged_line = hit_line;
        merged_line[{wsel, 5'b0} +: 32] = merged_word;
    end

    assign bus.mem_rdata = hit_word;

    always_comb begin
        state_d          = state_q;
        bus.mem_resp     = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = data_q[idx][victim_q];
        case (state_q)
            CHECK: begin
                if (req) begin
                    if (hit) begin
                        bus.mem_resp = 1'b1;
                    end else if (valid_q[idx][victim_way] && dirty_q[idx][victim_way]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[idx][victim_q], idx, {OFF_W{1'b0}}};
                if (bus.pmem_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {tag, idx, {OFF_W{1'b0}}};
                if (bus.pmem_resp) state_d = CHECK;
            end
            default: state_d = CHECK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CHECK;
            victim_q   <= '0;
            filled_q   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                CHECK: begin
                    if (req && hit) begin
                        plru_q[idx] <= plru_upd;
                        if (bus.mem_write) begin
                            data_q[idx][hit_way]  <= merged_line;
                            dirty_q[idx][hit_way] <= 1'b1;
                        end
                        if (!filled_q && hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
                        filled_q <= 1'b0;
                    end else if (req) begin
                        victim_q <= victim_way;
                        if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
                    end
                end
                ALLOCATE: begin
                    if (bus.pmem_resp) begin
                        data_q[idx][victim_q]  <= bus.pmem_rdata;
                        tag_q[idx][victim_q]   <= tag;
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= 1'b0;
                        filled_q               <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_nway.sv
// tb/tb_cache_nway.sv - self-checking bench for cache_nway (4 ways, 8 sets, 256-bit lines, 4-bit counters)
module tb_cache_nway;
    localparam int LW  = 256;
    localparam int CW  = 4;
    localparam int LAT = 2;
    localparam int K_HIT = 0, K_CLEAN = 1, K_DIRTY = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] hit_count, miss_count;

    cache_nway_if #(.LINE_WIDTH(LW)) bus ();

    cache_nway #(.NUM_WAYS(4), .NUM_SETS(8), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          kind;
        logic [31:0] victim;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rdata;
        int          cycles;
    } exp_t;

    typedef struct packed {
        logic          wr;
        logic [31:0]   addr;
        logic [LW-1:0] data;
    } pev_t;

    int checks = 0;
    int errors = 0;
    exp_t        exp_q[$];
    pev_t        pev_q[$];
    logic [LW-1:0] pstore [int unsigned];
    logic [31:0]   ref_mem [int unsigned];
    logic [CW-1:0] m_hit, m_miss;
    vec_t vecs[16];

    function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] pat_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h11223344;
        return (a * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    function automatic logic [LW-1:0] pline(input logic [31:0] a);
        logic [LW-1:0] l;
        if (pstore.exists(a)) return pstore[a];
        for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = pat_word(a + 32'(4 * k));
        return l;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0]   wa;
        logic [LW-1:0] l;
        wa = {a[31:2], 2'b00};
        if (ref_mem.exists(wa)) return ref_mem[wa];
        l = pline({a[31:5], 5'b0});
        return l[{a[4:2], 5'b0} +: 32];
    endfunction

    function automatic logic [LW-1:0] ref_line(input logic [31:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = ref_word(a + 32'(4 * k));
        return l;
    endfunction

    // Physical memory: answers LAT cycles after a request appears, one-cycle pmem_resp.
    initial begin
        int pcnt;
        pcnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                bus.pmem_resp = 1'b0;
                pcnt = 0;
            end else if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                pcnt++;
                if (pcnt == LAT) begin
                    pcnt = 0;
                    bus.pmem_resp = 1'b1;
                    pev_q.push_back('{bus.pmem_write, bus.pmem_address, bus.pmem_wdata});
                    if (bus.pmem_write) pstore[bus.pmem_address] = bus.pmem_wdata;
                    else bus.pmem_rdata = pline(bus.pmem_address);
                end
            end
        end
    end

    task automatic cpu_access(input logic [31:0] a, input logic wr, input logic [3:0] be,
                              input logic [31:0] wd, input string tag);
        int   cyc;
        exp_t e;
        @(negedge clk);
        bus.mem_address     = a;
        bus.mem_read        = !wr;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        cyc = 0;
        #1;
        while (!bus.mem_resp && cyc < 100) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        e = exp_q.pop_front();
        if (!bus.mem_resp) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for mem_resp", tag);
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end else begin
            if (e.chk_rdata) chk({tag, " rdata"}, bus.mem_rdata, e.rdata);
            chk({tag, " latency"}, cyc, e.cycles);
            @(posedge clk);
            #1;
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t          e;
        pev_t          ev;
        int            n_exp;
        logic [LW-1:0] wb_line;
        logic [31:0]   w;
        e.chk_rdata = !v.wr;
        e.rdata     = ref_word(v.addr);
        e.cycles    = (v.kind == K_HIT) ? 0 : (v.kind == K_CLEAN) ? (LAT + 1) : (2 * LAT + 2);
        exp_q.push_back(e);
        n_exp   = (v.kind == K_HIT) ? 0 : (v.kind == K_CLEAN) ? 1 : 2;
        wb_line = ref_line(v.victim);
        if (v.kind == K_HIT) begin
            if (m_hit != '1) m_hit++;
        end else begin
            if (m_miss != '1) m_miss++;
        end
        if (v.wr) begin
            w = ref_word(v.addr);
            for (int b = 0; b < 4; b++) if (v.be[b]) w[8*b +: 8] = v.wdata[8*b +: 8];
            ref_mem[{v.addr[31:2], 2'b00}] = w;
        end
        cpu_access(v.addr, v.wr, v.be, v.wdata, tag);
        chk({tag, " pmem count"}, pev_q.size(), n_exp);
        if (pev_q.size() == n_exp) begin
            if (v.kind == K_DIRTY) begin
                ev = pev_q.pop_front();
                chk({tag, " wb is write"}, ev.wr, 1'b1);
                chk({tag, " wb addr"}, ev.addr, v.victim);
                chk({tag, " wb data"}, ev.data, wb_line);
            end
            if (v.kind != K_HIT) begin
                ev = pev_q.pop_front();
                chk({tag, " fill is read"}, ev.wr, 1'b0);
                chk({tag, " fill addr"}, ev.addr, {v.addr[31:5], 5'b0});
            end
        end
        pev_q.delete();
        chk({tag, " hit_count"}, hit_count, m_hit);
        chk({tag, " miss_count"}, miss_count, m_miss);
    endtask

    initial begin
        vecs[0]  = '{32'h040, 1'b0, 4'h0, 32'h0,        K_CLEAN, 32'h0};
        vecs[1]  = '{32'h040, 1'b0, 4'h0, 32'h0,        K_HIT,   32'h0};
        vecs[2]  = '{32'h040, 1'b1, 4'h3, 32'hAABBCCDD, K_HIT,   32'h0};
        vecs[3]  = '{32'h040, 1'b0, 4'h0, 32'h0,        K_HIT,   32'h0};
        vecs[4]  = '{32'h000, 1'b0, 4'h0, 32'h0,        K_CLEAN, 32'h0};
        vecs[5]  = '{32'h100, 1'b0, 4'h0, 32'h0,        K_CLEAN, 32'h0};
        vecs[6]  = '{32'h200, 1'b0, 4'h0, 32'h0,        K_CLEAN, 32'h0};
        vecs[7]  = '{32'h300, 1'b0, 4'h0, 32'h0,        K_CLEAN, 32'h0};
        vecs[8]  = '{32'h400, 1'b0, 4'h0, 32'h0,        K_CLEAN, 32'h0};
        vecs[9]  = '{32'h000, 1'b0, 4'h0, 32'h0,        K_CLEAN, 32'h0};
        vecs[10] = '{32'h000, 1'b1, 4'hF, 32'hDEADBEEF, K_HIT,   32'h0};
        vecs[11] = '{32'h100, 1'b0, 4'h0, 32'h0,        K_HIT,   32'h0};
        vecs[12] = '{32'h300, 1'b0, 4'h0, 32'h0,        K_HIT,   32'h0};
        vecs[13] = '{32'h400, 1'b0, 4'h0, 32'h0,        K_HIT,   32'h0};
        vecs[14] = '{32'h500, 1'b0, 4'h0, 32'h0,        K_DIRTY, 32'h000};
        vecs[15] = '{32'h000, 1'b0, 4'h0, 32'h0,        K_CLEAN, 32'h0};

        rst = 1'b1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_byte_enable = 4'h0;
        bus.mem_address = 32'h0;
        bus.mem_wdata = 32'h0;
        m_hit = '0;
        m_miss = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset hit_count", hit_count, 0);
        chk("reset miss_count", miss_count, 0);
        chk("reset mem_resp", bus.mem_resp, 0);
        chk("reset pmem_read", bus.pmem_read, 0);
        chk("reset pmem_write", bus.pmem_write, 0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Hit counter saturation: 0x000 is resident.
        for (int i = 0; i < 20; i++) run_vec('{32'h000, 1'b0, 4'h0, 32'h0, K_HIT, 32'h0}, $sformatf("sat%0d", i));
        chk("saturated hit_count", hit_count, 4'hF);

        // Reset while a fill is outstanding.
        @(negedge clk);
        bus.mem_address = 32'h600;
        bus.mem_read    = 1'b1;
        @(negedge clk);
        #1;
        chk("alloc pmem_read", bus.pmem_read, 1'b1);
        chk("alloc pmem_address", bus.pmem_address, 32'h600);
        rst = 1'b1;
        bus.mem_read = 1'b0;
        @(negedge clk);
        #1;
        chk("rst drops pmem_read", bus.pmem_read, 1'b0);
        chk("rst hit_count", hit_count, 0);
        chk("rst miss_count", miss_count, 0);
        chk("rst no pmem event", pev_q.size(), 0);
        rst = 1'b0;
        pev_q.delete();
        ref_mem.delete();
        m_hit = '0;
        m_miss = '0;
        run_vec('{32'h600, 1'b0, 4'h0, 32'h0, K_CLEAN, 32'h0}, "post_rst 600");
        run_vec('{32'h040, 1'b0, 4'h0, 32'h0, K_CLEAN, 32'h0}, "post_rst 040");
        run_vec('{32'h600, 1'b0, 4'h0, 32'h0, K_HIT,   32'h0}, "post_rst 600 again");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
